// File: rtl/masking_pkg.sv
// masking_pkg
// Shared definitions for the masked-datapath output stage: share lane width,
// default share/byte counts, the packed share vector type and the FSM state
// encoding used by the unmasker.
package masking_pkg;

    localparam int SHARE_W        = 8;
    localparam int DEF_NUM_SHARES = 8;
    localparam int DEF_NUM_BYTES  = 16;

    // Share i of a masked byte lives in element [i]; x = s0 ^ s1 ^ ... ^ s(N-1).
    typedef logic [DEF_NUM_SHARES-1:0][SHARE_W-1:0] share_vec_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FOLD = 2'd1,
        OUT  = 2'd2
    } unmask_state_e;

endpackage

// File: rtl/masked_state_unmasker_if.sv
// masked_state_unmasker_if
// Bundles the two valid/ready streams of the unmasker.
//   in_valid/in_ready/in_shares    : masked byte input, share i at [8*i+7:8*i]
//   out_valid/out_ready/out_block  : unmasked block output, byte 0 in the MSBs
//   busy                           : unmasker holds a partial or complete block
// Modports: master = upstream/sink side, slave = unmasker side.
interface masked_state_unmasker_if
    import masking_pkg::*;
#(
    parameter int NUM_SHARES = DEF_NUM_SHARES,
    parameter int NUM_BYTES  = DEF_NUM_BYTES
);

    logic                            in_valid;
    logic                            in_ready;
    logic [NUM_SHARES*SHARE_W-1:0]   in_shares;
    logic                            out_valid;
    logic                            out_ready;
    logic [NUM_BYTES*SHARE_W-1:0]    out_block;
    logic                            busy;

    modport master (
        output in_valid, in_shares, out_ready,
        input  in_ready, out_valid, out_block, busy
    );

    modport slave (
        input  in_valid, in_shares, out_ready,
        output in_ready, out_valid, out_block, busy
    );

endinterface

// File: rtl/share_fold_acc.sv
// share_fold_acc
// Recombines one masked byte by folding a single share per cycle into a
// registered accumulator, so no combinational cone ever sees every share.
// Ports:
//   clk, rst  : clock, synchronous active-high reset (zeroises all shares)
//   load      : capture shares, seed acc with share 0, share_idx <= 1
//   fold      : one fold step per cycle while high
//   shares    : masked byte, element i = share i
//   done      : high on the fold cycle that consumes the last share
//   result    : acc ^ share_reg[share_idx]; the unmasked byte when done is high
module share_fold_acc
    import masking_pkg::*;
#(
    parameter int NUM_SHARES = DEF_NUM_SHARES
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 load,
    input  logic                                 fold,
    input  logic [NUM_SHARES-1:0][SHARE_W-1:0]   shares,
    output logic                                 done,
    output logic [SHARE_W-1:0]                   result
);

    localparam int SIDX_W = $clog2(NUM_SHARES);

    logic [NUM_SHARES-1:0][SHARE_W-1:0] share_reg;
    logic [SHARE_W-1:0]                 acc;
    logic [SIDX_W-1:0]                  share_idx;

    assign result = acc ^ share_reg[share_idx];
    assign done   = fold && (share_idx == SIDX_W'(NUM_SHARES - 1));

    // Shares are wiped as soon as the last one is consumed so that a finished
    // byte leaves no residual mask material behind in the share register.
    always_ff @(posedge clk) begin
        if (rst) begin
            share_reg <= '0;
            acc       <= '0;
            share_idx <= '0;
        end else if (load) begin
            share_reg <= shares;
            acc       <= shares[0];
            share_idx <= SIDX_W'(1);
        end else if (done) begin
            share_reg <= '0;
            acc       <= '0;
            share_idx <= '0;
        end else if (fold) begin
            acc       <= result;
            share_idx <= share_idx + SIDX_W'(1);
        end
    end

endmodule

// File: rtl/masked_state_unmasker.sv
// masked_state_unmasker
// Output end of the masked AES datapath. Accepts one masked byte per
// handshake, recombines it through share_fold_acc (NUM_SHARES-1 fold cycles),
// packs NUM_BYTES results into a block and presents it on a valid/ready port.
// Ports:
//   clk  : single rising-edge clock
//   rst  : synchronous active-high reset; discards any partial/held block
//   bus  : slave side of masked_state_unmasker_if (in/out streams + busy)
module masked_state_unmasker
    import masking_pkg::*;
#(
    parameter int NUM_SHARES = DEF_NUM_SHARES,
    parameter int NUM_BYTES  = DEF_NUM_BYTES
) (
    input  logic                      clk,
    input  logic                      rst,
    masked_state_unmasker_if.slave    bus
);

    localparam int BCNT_W = $clog2(NUM_BYTES);

    unmask_state_e                      state;
    logic [BCNT_W-1:0]                  byte_cnt;
    logic [NUM_BYTES-1:0][SHARE_W-1:0]  block_reg;
    logic                               out_valid_r;
    logic                               in_ready_w;
    logic                               accept;
    logic                               fold_done;
    logic [SHARE_W-1:0]                 fold_byte;
    logic [NUM_SHARES-1:0][SHARE_W-1:0] shares_in;

    assign shares_in = bus.in_shares;

    // in_ready is decoded from the state flop and gated by rst so that it is
    // low while reset is asserted yet already high in the first cycle after.
    assign in_ready_w    = (state == IDLE) && !rst;
    assign accept        = bus.in_valid && in_ready_w;

    assign bus.in_ready  = in_ready_w;
    assign bus.out_valid = out_valid_r;
    assign bus.out_block = out_valid_r ? block_reg : '0;
    assign bus.busy      = !((state == IDLE) && (byte_cnt == '0));

    share_fold_acc #(
        .NUM_SHARES (NUM_SHARES)
    ) u_fold (
        .clk    (clk),
        .rst    (rst),
        .load   (accept),
        .fold   (state == FOLD),
        .shares (shares_in),
        .done   (fold_done),
        .result (fold_byte)
    );

    // Block assembly FSM. Byte k lands in element NUM_BYTES-1-k so byte 0
    // ends up in the MSBs of out_block. byte_cnt only returns to zero via
    // the output handshake, so no byte can be overwritten before delivery.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            byte_cnt    <= '0;
            block_reg   <= '0;
            out_valid_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state <= FOLD;
                    end
                end
                FOLD: begin
                    if (fold_done) begin
                        block_reg[BCNT_W'(NUM_BYTES - 1) - byte_cnt] <= fold_byte;
                        if (byte_cnt == BCNT_W'(NUM_BYTES - 1)) begin
                            state       <= OUT;
                            out_valid_r <= 1'b1;
                        end else begin
                            byte_cnt <= byte_cnt + BCNT_W'(1);
                            state    <= IDLE;
                        end
                    end
                end
                OUT: begin
                    if (out_valid_r && bus.out_ready) begin
                        block_reg   <= '0;
                        byte_cnt    <= '0;
                        out_valid_r <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
